prog_mux_seq: RTL and testbench
===============================

PROG_MUX_SEQ -- requirements
Module: prog_mux_seq

Interface
REQ-001 The block SHALL have parameter N_CH, default 8: number of pad channels switchable between functional and programming paths.
REQ-002 The block SHALL have parameter PULSE_W, default 16: width of the drain-pulse length field.
REQ-003 The block SHALL have parameter DEAD_CYC, default 4: break-before-make dead time in cycles; legal range is 1 to 255.
REQ-004 The block SHALL have port mclk, input, 1: the single clock.
REQ-005 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 The block SHALL have port cmd_valid, input, 1: command request.
REQ-007 The block SHALL have port cmd_ready, output, 1: command accepted when high together with cmd_valid.
REQ-008 The block SHALL have port cmd_ch, input, clog2(N_CH): target channel.
REQ-009 The block SHALL have port cmd_len, input, PULSE_W: drain pulse length in cycles.
REQ-010 The block SHALL have port abort, input, 1: terminate the sequence in progress.
REQ-011 The block SHALL have port fn_en, output, N_CH: per-channel functional-path enable.
REQ-012 The block SHALL have port prog_sel, output, N_CH: per-channel programming-path select.
REQ-013 The block SHALL have port drain_pulse, output, 1: programming drain pulse.
REQ-014 The block SHALL have port busy, output, 1: sequence in progress.
REQ-015 The block SHALL have port done, output, 1: one-cycle completion strobe.
REQ-016 The block SHALL have port aborted, output, 1: qualifies done; high when the sequence was aborted.
REQ-017 The block SHALL have port err, output, 1: one-cycle strobe for an illegal command.

Function
REQ-018 The block SHALL implement states IDLE, BREAK, CONNECT, PULSE, DISCONNECT and DONE.
REQ-019 cmd_ready SHALL equal (state == IDLE); a command is accepted on the edge where cmd_valid and cmd_ready are both high.
REQ-020 An accepted command with cmd_ch >= N_CH or cmd_len == 0 SHALL be rejected: err pulses high for the following cycle, the state stays IDLE, and no output other than err changes.
REQ-021 A legal accepted command SHALL latch cmd_ch and cmd_len and enter BREAK on the next cycle.
REQ-022 In BREAK, fn_en[ch] SHALL be 0 and prog_sel SHALL be all zeros for DEAD_CYC cycles, then the state SHALL move to CONNECT.
REQ-023 In CONNECT, prog_sel[ch] SHALL be 1 for DEAD_CYC cycles, then the state SHALL move to PULSE.
REQ-024 In PULSE, drain_pulse SHALL be 1 for exactly cmd_len cycles while prog_sel[ch] stays 1, then the state SHALL move to DISCONNECT.
REQ-025 In DISCONNECT, drain_pulse and prog_sel SHALL be 0 and fn_en[ch] SHALL stay 0 for DEAD_CYC cycles, then the state SHALL move to DONE.
REQ-026 DONE SHALL last one cycle: done is 1, fn_en[ch] returns to 1, and the state moves to IDLE.
REQ-027 Latency from the accept edge to the done cycle SHALL be exactly 3*DEAD_CYC + cmd_len + 1 cycles when no abort occurs.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 When abort is high in BREAK, CONNECT or PULSE, the next cycle SHALL be DISCONNECT with drain_pulse and prog_sel at 0, followed by the normal DISCONNECT and DONE sequence, with aborted = 1 during DONE.
REQ-030 abort SHALL be ignored in IDLE, DISCONNECT and DONE.
REQ-031 When abort and cmd_valid are both high in IDLE, the command SHALL be accepted normally.
REQ-032 prog_sel SHALL always be zero or one-hot, and only on the latched channel.
REQ-033 For every channel i, fn_en[i] and prog_sel[i] SHALL never both be 1.
REQ-034 drain_pulse SHALL be 1 only while prog_sel is non-zero.
REQ-035 All outputs SHALL be registered.
REQ-036 Channels other than the latched channel SHALL keep fn_en = 1 throughout the sequence.
REQ-037 The pulse counter SHALL be PULSE_W bits wide; cmd_len = 2^PULSE_W - 1 SHALL complete without wrap-around.

Reset
REQ-038 Reset SHALL be synchronous and active-high on mclk.
REQ-039 While reset is high, the block SHALL force state IDLE, fn_en all ones, prog_sel all zeros, drain_pulse 0, busy 0, done 0, aborted 0, err 0, cmd_ready 0, and clear all counters.
REQ-040 Reset asserted mid-sequence SHALL take effect on the next edge, with no done strobe; cmd_ready SHALL be 1 on the first cycle after reset is released.

Structure
REQ-041 A shared package prog_mux_pkg SHALL hold the state enum type and the default DEAD_CYC value.
REQ-042 A single sub-module prog_mux_timer SHALL provide the loadable down-counter used for dead-time and pulse timing, with inputs load, value and an expire output.

Verification
REQ-043 With N_CH=8 and DEAD_CYC=4, cmd ch=3, len=10 -> fn_en[3] falls 1 cycle after accept, prog_sel=0x08 for 14 cycles, drain_pulse high for 10 cycles, done at accept+23, aborted=0.
REQ-044 cmd ch=9, len=5 with N_CH=8 -> err for 1 cycle, state stays IDLE, fn_en=0xFF, no done.
REQ-045 cmd ch=2, len=100, abort asserted on the 3rd PULSE cycle -> drain_pulse low on the next cycle, done 5 cycles later with aborted=1, fn_en=0xFF afterwards.
REQ-046 reset asserted during PULSE -> next cycle prog_sel=0, drain_pulse=0, fn_en=0xFF, no done; cmd_ready=1 on the first cycle after release.
REQ-047 Back-to-back commands ch=0 then ch=7 with cmd_valid held high -> second accept exactly 1 cycle after the first done; assertions for REQ-032 to REQ-034 hold throughout.
REQ-048 PULSE_W=4, cmd_len=15, DEAD_CYC=1 -> drain_pulse high for exactly 15 cycles, total latency 19 cycles.

Source files
------------

// File: rtl/prog_mux_pkg.sv
// Shared types and defaults for the programming-mux sequencer.
// Holds the sequencer state enum, the default break-before-make dead time,
// and a small width helper used when sizing the shared timer.
package prog_mux_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_BREAK      = 3'd1,
    ST_CONNECT    = 3'd2,
    ST_PULSE      = 3'd3,
    ST_DISCONNECT = 3'd4,
    ST_DONE       = 3'd5
  } state_t;

  // Break-before-make dead time in cycles (legal range 1..255).
  localparam int DEAD_CYC_DEFAULT = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/prog_mux_timer.sv
// Loadable down-counter shared by the dead-time and drain-pulse phases.
// Ports: mclk/reset (sync, active-high); load/value reload the count;
//        expire is high during the last cycle of a loaded interval.
module prog_mux_timer #(
  parameter int W = 16
) (
  input  logic         mclk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;

  // A value N loaded on the edge that enters a phase makes expire rise in
  // the N-th cycle of that phase, so the phase lasts exactly N cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/prog_mux_seq.sv
// Break-before-make sequencer switching one pad channel from its functional
// path to the programming path, issuing a drain pulse, then switching back.
// Ports: mclk/reset (sync, active-high); cmd_valid/cmd_ready/cmd_ch/cmd_len
//        command handshake; abort; fn_en/prog_sel per-channel path controls;
//        drain_pulse, busy, done, aborted, err status. All outputs registered.
module prog_mux_seq
  import prog_mux_pkg::*;
#(
  parameter int N_CH     = 8,
  parameter int PULSE_W  = 16,
  parameter int DEAD_CYC = DEAD_CYC_DEFAULT
) (
  input  logic                    mclk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [$clog2(N_CH)-1:0] cmd_ch,
  input  logic [PULSE_W-1:0]      cmd_len,
  input  logic                    abort,
  output logic [N_CH-1:0]         fn_en,
  output logic [N_CH-1:0]         prog_sel,
  output logic                    drain_pulse,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic                    err
);

  localparam int CH_W = $clog2(N_CH);
  // Timer must hold both the dead time (up to 255) and the full pulse length.
  localparam int TW   = max_int(PULSE_W, 8);

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [PULSE_W-1:0]  len_q, len_d;
  logic                abort_q, abort_d;

  logic                tmr_load;
  logic [TW-1:0]       tmr_value;
  logic                tmr_expire;

  logic                accept;
  logic                cmd_legal;
  logic [N_CH-1:0]     ch_oh;

  logic [N_CH-1:0]     fn_en_d, prog_sel_d;
  logic                drain_pulse_d, busy_d, done_d, aborted_d, err_d, cmd_ready_d;

  prog_mux_timer #(.W(TW)) u_timer (
    .mclk   (mclk),
    .reset  (reset),
    .load   (tmr_load),
    .value  (tmr_value),
    .expire (tmr_expire)
  );

  // cmd_ready is the registered copy of (state == IDLE); it is held low by
  // reset, so nothing is accepted until the first cycle after release.
  assign accept    = cmd_valid & cmd_ready;
  assign cmd_legal = (int'(cmd_ch) < N_CH) && (cmd_len != '0);

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    len_d     = len_q;
    abort_d   = abort_q;
    tmr_load  = 1'b0;
    tmr_value = TW'(DEAD_CYC);
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_legal) begin
            state_d  = ST_BREAK;
            ch_d     = cmd_ch;
            len_d    = cmd_len;
            abort_d  = 1'b0;
            tmr_load = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_BREAK: begin
        if (abort) begin
          state_d  = ST_DISCONNECT;
          abort_d  = 1'b1;
          tmr_load = 1'b1;
        end else if (tmr_expire) begin
          state_d  = ST_CONNECT;
          tmr_load = 1'b1;
        end
      end
      ST_CONNECT: begin
        if (abort) begin
          state_d  = ST_DISCONNECT;
          abort_d  = 1'b1;
          tmr_load = 1'b1;
        end else if (tmr_expire) begin
          state_d   = ST_PULSE;
          tmr_load  = 1'b1;
          tmr_value = TW'(len_q);
        end
      end
      ST_PULSE: begin
        if (abort) begin
          state_d  = ST_DISCONNECT;
          abort_d  = 1'b1;
          tmr_load = 1'b1;
        end else if (tmr_expire) begin
          state_d  = ST_DISCONNECT;
          tmr_load = 1'b1;
        end
      end
      ST_DISCONNECT: begin
        if (tmr_expire) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so that, once registered, they
  // line up cycle-for-cycle with the state register.
  always_comb begin
    ch_oh         = N_CH'(1) << ch_d;
    fn_en_d       = '1;
    prog_sel_d    = '0;
    drain_pulse_d = 1'b0;
    done_d        = 1'b0;
    aborted_d     = 1'b0;
    busy_d        = (state_d != ST_IDLE);
    cmd_ready_d   = (state_d == ST_IDLE);

    case (state_d)
      ST_BREAK, ST_DISCONNECT: begin
        fn_en_d = ~ch_oh;
      end
      ST_CONNECT: begin
        fn_en_d    = ~ch_oh;
        prog_sel_d = ch_oh;
      end
      ST_PULSE: begin
        fn_en_d       = ~ch_oh;
        prog_sel_d    = ch_oh;
        drain_pulse_d = 1'b1;
      end
      ST_DONE: begin
        done_d    = 1'b1;
        aborted_d = abort_d;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      len_q       <= '0;
      abort_q     <= 1'b0;
      fn_en       <= '1;
      prog_sel    <= '0;
      drain_pulse <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      err         <= 1'b0;
      cmd_ready   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      len_q       <= len_d;
      abort_q     <= abort_d;
      fn_en       <= fn_en_d;
      prog_sel    <= prog_sel_d;
      drain_pulse <= drain_pulse_d;
      busy        <= busy_d;
      done        <= done_d;
      aborted     <= aborted_d;
      err         <= err_d;
      cmd_ready   <= cmd_ready_d;
    end
  end

endmodule

// File: tb/tb_prog_mux_seq.sv
// Directed bench for prog_mux_seq: a default 8-channel instance (A) and a
// 6-channel, PULSE_W=4, DEAD_CYC=1 instance (B). A 3-bit channel field cannot
// encode ch=9, so the illegal-channel path is driven on B with ch=7.
module tb_prog_mux_seq;

  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  logic reset;

  logic        a_cmd_valid, a_cmd_ready, a_abort;
  logic [2:0]  a_cmd_ch;
  logic [15:0] a_cmd_len;
  logic [7:0]  a_fn_en, a_prog_sel;
  logic        a_drain_pulse, a_busy, a_done, a_aborted, a_err;

  logic        b_cmd_valid, b_cmd_ready, b_abort;
  logic [2:0]  b_cmd_ch;
  logic [3:0]  b_cmd_len;
  logic [5:0]  b_fn_en, b_prog_sel;
  logic        b_drain_pulse, b_busy, b_done, b_aborted, b_err;

  prog_mux_seq #(.N_CH(8), .PULSE_W(16), .DEAD_CYC(4)) dut_a (
    .mclk(mclk), .reset(reset),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_ch(a_cmd_ch), .cmd_len(a_cmd_len),
    .abort(a_abort), .fn_en(a_fn_en), .prog_sel(a_prog_sel), .drain_pulse(a_drain_pulse),
    .busy(a_busy), .done(a_done), .aborted(a_aborted), .err(a_err)
  );

  prog_mux_seq #(.N_CH(6), .PULSE_W(4), .DEAD_CYC(1)) dut_b (
    .mclk(mclk), .reset(reset),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_ch(b_cmd_ch), .cmd_len(b_cmd_len),
    .abort(b_abort), .fn_en(b_fn_en), .prog_sel(b_prog_sel), .drain_pulse(b_drain_pulse),
    .busy(b_busy), .done(b_done), .aborted(b_aborted), .err(b_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  // Path-safety invariants sampled on every falling edge.
  always @(negedge mclk) begin
    check("a_sel_onehot0", 32'($onehot0(a_prog_sel)), 1);
    check("a_fn_sel_overlap", 32'(a_fn_en & a_prog_sel), 0);
    check("a_drain_without_sel", 32'(a_drain_pulse && (a_prog_sel == 8'h00)), 0);
    check("a_fn_others_on", 32'($countones(~a_fn_en) <= 1), 1);
    check("b_sel_onehot0", 32'($onehot0(b_prog_sel)), 1);
    check("b_fn_sel_overlap", 32'(b_fn_en & b_prog_sel), 0);
    check("b_drain_without_sel", 32'(b_drain_pulse && (b_prog_sel == 6'h00)), 0);
  end

  // Per-sequence observations on instance A.
  int         r_done_at, r_prog, r_drain, r_badsel;
  logic [7:0] r_fn1, r_fn_done;
  logic       r_aborted;

  // Issue one command on A, then observe until done. k=1 is the first cycle
  // after the accept edge. abort_pc>0 raises abort in that PULSE cycle.
  task automatic a_cmd(input int ch, input int len, input int abort_pc, input bit abort_on_accept);
    logic [7:0] sel_exp;
    sel_exp     = 8'h01 << ch;
    a_cmd_ch    = 3'(ch);
    a_cmd_len   = 16'(len);
    a_cmd_valid = 1'b1;
    a_abort     = abort_on_accept;
    for (int i = 0; i < 100 && !a_cmd_ready; i++) tick();
    tick();
    a_cmd_valid = 1'b0;
    a_abort     = 1'b0;
    r_done_at = 0; r_prog = 0; r_drain = 0; r_badsel = 0;
    r_fn1 = '0; r_fn_done = '0; r_aborted = 1'b0;
    for (int k = 1; k <= 1000; k++) begin
      if (k == 1) r_fn1 = a_fn_en;
      if (a_prog_sel != 8'h00) begin
        r_prog++;
        if (a_prog_sel != sel_exp) r_badsel++;
      end
      if (a_drain_pulse) r_drain++;
      a_abort = (abort_pc != 0) && a_drain_pulse && (r_drain == abort_pc);
      if (a_done) begin
        r_done_at = k;
        r_aborted = a_aborted;
        r_fn_done = a_fn_en;
        break;
      end
      tick();
    end
    a_abort = 1'b0;
  endtask

  initial begin : stim
    int acc1, acc2, d1, d2, seen, bdone, bprog, bdrain;
    logic [5:0] bfn1;

    reset = 1'b1;
    a_cmd_valid = 0; a_abort = 0; a_cmd_ch = '0; a_cmd_len = '0;
    b_cmd_valid = 0; b_abort = 0; b_cmd_ch = '0; b_cmd_len = '0;
    tick(); tick();

    // Reset state
    check("rst_fn_en", a_fn_en, 8'hFF);
    check("rst_prog_sel", a_prog_sel, 0);
    check("rst_drain", a_drain_pulse, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_aborted", a_aborted, 0);
    check("rst_err", a_err, 0);
    check("rst_cmd_ready", a_cmd_ready, 0);
    reset = 1'b0;
    tick();
    check("rdy_after_rst_a", a_cmd_ready, 1);
    check("rdy_after_rst_b", b_cmd_ready, 1);

    // Nominal: ch=3, len=10 -> latency 3*4+10+1 = 23
    a_cmd(3, 10, 0, 0);
    check("nom_fn1", r_fn1, 8'hF7);
    check("nom_prog_cycles", r_prog, 14);
    check("nom_drain_cycles", r_drain, 10);
    check("nom_badsel", r_badsel, 0);
    check("nom_done_at", r_done_at, 23);
    check("nom_aborted", r_aborted, 0);
    check("nom_fn_done", r_fn_done, 8'hFF);

    // Zero length is rejected
    tick();
    a_cmd_ch = 3'd1; a_cmd_len = 16'd0; a_cmd_valid = 1'b1;
    tick();
    a_cmd_valid = 1'b0;
    check("len0_err", a_err, 1);
    check("len0_busy", a_busy, 0);
    check("len0_fn_en", a_fn_en, 8'hFF);
    check("len0_ready", a_cmd_ready, 1);
    tick();
    check("len0_err_clear", a_err, 0);
    check("len0_done", a_done, 0);

    // Abort on the 3rd PULSE cycle: pulse k=9..11, DISC 12..15, DONE 16
    a_cmd(2, 100, 3, 0);
    check("abt_drain_cycles", r_drain, 3);
    check("abt_prog_cycles", r_prog, 7);
    check("abt_done_at", r_done_at, 16);
    check("abt_aborted", r_aborted, 1);
    check("abt_fn_done", r_fn_done, 8'hFF);
    tick();
    check("abt_fn_after", a_fn_en, 8'hFF);

    // abort with cmd_valid in IDLE: accepted normally, not aborted
    a_cmd(6, 1, 0, 1);
    check("idle_abt_fn1", r_fn1, 8'hBF);
    check("idle_abt_done_at", r_done_at, 14);
    check("idle_abt_aborted", r_aborted, 0);
    check("idle_abt_drain", r_drain, 1);

    // Reset during PULSE
    tick();
    a_cmd_ch = 3'd5; a_cmd_len = 16'd50; a_cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !a_cmd_ready; i++) tick();
    tick();
    a_cmd_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (a_drain_pulse) begin seen = 1; break; end
      tick();
    end
    check("rstp_reached_pulse", seen, 1);
    tick();
    reset = 1'b1;
    tick();
    check("rstp_prog_sel", a_prog_sel, 0);
    check("rstp_drain", a_drain_pulse, 0);
    check("rstp_fn_en", a_fn_en, 8'hFF);
    check("rstp_done", a_done, 0);
    check("rstp_busy", a_busy, 0);
    reset = 1'b0;
    tick();
    check("rstp_ready", a_cmd_ready, 1);
    check("rstp_done_after", a_done, 0);

    // Back-to-back with cmd_valid held: ch=0 then ch=7, len=3 -> latency 16
    acc1 = -1; acc2 = -1; d1 = -1; d2 = -1;
    a_cmd_ch = 3'd0; a_cmd_len = 16'd3; a_cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (acc2 >= 0 && i == acc2 + 1) begin
        a_cmd_valid = 1'b0;
        check("b2b_fn_second", a_fn_en, 8'h7F);
      end
      if (a_done) begin
        if (d1 < 0) begin d1 = i; a_cmd_ch = 3'd7; end
        else begin d2 = i; break; end
      end
      if (a_cmd_valid && a_cmd_ready) begin
        if (acc1 < 0) acc1 = i;
        else if (acc2 < 0) acc2 = i;
      end
      tick();
    end
    a_cmd_valid = 1'b0;
    check("b2b_lat1", d1 - acc1, 16);
    check("b2b_gap", acc2 - d1, 1);
    check("b2b_lat2", d2 - acc2, 16);

    // Instance B: ch=7 >= N_CH=6 is rejected
    b_cmd_ch = 3'd7; b_cmd_len = 4'd5; b_cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !b_cmd_ready; i++) tick();
    tick();
    b_cmd_valid = 1'b0;
    check("badch_err", b_err, 1);
    check("badch_busy", b_busy, 0);
    check("badch_fn_en", b_fn_en, 6'h3F);
    check("badch_done", b_done, 0);
    tick();
    check("badch_err_clear", b_err, 0);
    check("badch_done2", b_done, 0);

    // Instance B: max length 15, DEAD_CYC=1 -> latency 3+15+1 = 19
    b_cmd_ch = 3'd4; b_cmd_len = 4'd15; b_cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !b_cmd_ready; i++) tick();
    tick();
    b_cmd_valid = 1'b0;
    bdone = 0; bprog = 0; bdrain = 0; bfn1 = '0;
    for (int k = 1; k <= 100; k++) begin
      if (k == 1) bfn1 = b_fn_en;
      if (b_prog_sel != 6'h00) bprog++;
      if (b_drain_pulse) bdrain++;
      if (b_done) begin
        bdone = k;
        check("maxlen_aborted", b_aborted, 0);
        break;
      end
      tick();
    end
    check("maxlen_fn1", bfn1, 6'h2F);
    check("maxlen_drain", bdrain, 15);
    check("maxlen_prog", bprog, 16);
    check("maxlen_done_at", bdone, 19);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
